// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded RV32I instruction fields into 32-bit words, buffers them in a FIFO and
//   streams them into instruction memory at incrementing word addresses, starting at
//   BaseAddr. Acts as the program loader / self-test generator ahead of fetch.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   flush_i              sync clear: FIFO empty, address to BaseAddr, count and err cleared
//   in_valid_i/in_ready_o descriptor handshake
//   fmt_i                0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal (accepted and dropped)
//   op_i, funct3_i, funct7b5_i, rd_i, rs1_i, rs2_i, imm_i   descriptor fields
//   imem_we_o, imem_addr_o, imem_wdata_o, imem_ready_i      memory write port
//   count_o              words written since reset/flush, saturating
//   err_o                sticky: a descriptor was dropped
//
// Configuration
//   ENC_ALIGN_CHECK_EN   when defined, drops B/J descriptors with an odd immediate and
//                        S/I descriptors whose immediate is outside the signed 12-bit range.

module instr_encoder_loader #(
  parameter int unsigned      Depth    = 4,
  parameter int unsigned      AddrW    = 32,
  parameter logic [AddrW-1:0] BaseAddr = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       fmt_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             imem_we_o,
  output logic [AddrW-1:0] imem_addr_o,
  output logic [31:0]      imem_wdata_o,
  input  logic             imem_ready_i,
  output logic [15:0]      count_o,
  output logic             err_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [Depth];
  logic [PtrW:0]     wptr_q, wptr_d;
  logic [PtrW:0]     rptr_q, rptr_d;
  logic [PtrW:0]     occ, occ_next;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;

  logic              full, empty;
  logic              accept, push, pop;
  logic [31:0]       enc_word;
  logic              enc_legal;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign occ   = wptr_q - rptr_q;

  // Gated by reset so the port reads 0 while reset is held.
  assign in_ready_o = rst_ni & ~full & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign push       = accept & enc_legal;
  assign pop        = (state_q == StWrite) & imem_ready_i & ~flush_i;

  // Field packer.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (fmt_i)
      3'd0: enc_word = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      3'd1: begin
        if (op_i == 7'b0010011 && (funct3_i == 3'b001 || funct3_i == 3'b101)) begin
          // Shift-immediate: upper bits carry funct7, only shamt comes from imm.
          enc_word = {1'b0, funct7b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, op_i};
        end else begin
          enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
        end
      end
      3'd2: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
      3'd3: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1],
                        imm_i[11], op_i};
      3'd4: enc_word = {imm_i[31:12], rd_i, op_i};
      3'd5: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
      default: enc_legal = 1'b0;
    endcase
`ifdef ENC_ALIGN_CHECK_EN
    // Signed 12-bit range means bits 31..11 are all equal.
    if ((fmt_i == 3'd1 || fmt_i == 3'd2) && !((&imm_i[31:11]) || !(|imm_i[31:11]))) begin
      enc_legal = 1'b0;
    end
    if ((fmt_i == 3'd3 || fmt_i == 3'd5) && imm_i[0]) begin
      enc_legal = 1'b0;
    end
`endif
  end

  // Writer FSM and bookkeeping next-state.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    occ_next = occ + (PtrW+1)'(push) - (PtrW+1)'(pop);

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (accept && !enc_legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // Go straight to WRITE on the accepting edge to meet one-cycle latency.
        if (push || !empty) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (pop) begin
          rptr_d  = rptr_q + 1'b1;
          addr_d  = addr_q + AddrW'(4);
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          if (occ_next == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
      wptr_d  = '0;
      rptr_d  = '0;
      addr_d  = BaseAddr;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= BaseAddr;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[PtrW-1:0]] <= enc_word;
    end
  end

  assign imem_we_o    = (state_q == StWrite);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = imem_we_o ? mem_q[rptr_q[PtrW-1:0]] : 32'd0;
  assign count_o      = count_q;
  assign err_o        = err_q;

endmodule
